// File: rtl/cnt_dn_if.sv
// rtl/cnt_dn_if.sv - control/status bundle for the cnt_dn down counter
//
// Purpose: groups the counter's command inputs and status outputs so the
// counter and whatever drives it share one typed connection.
// Signals:
//   en        count enable (one decrement per enabled cycle)
//   load      load strobe, wins over en
//   load_val  value captured on load
//   out       current count, registered
//   out_pulse one-cycle strobe on the first cycle out equals MATCH
//   zero      high while out == 0
//   busy      high while the counter is in RUN
// Modports: master drives commands and reads status; slave is the counter.

interface cnt_dn_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             out_pulse;
  logic             zero;
  logic             busy;

  modport master (
    output en, load, load_val,
    input  out, out_pulse, zero, busy
  );

  modport slave (
    input  en, load, load_val,
    output out, out_pulse, zero, busy
  );
endinterface

// File: rtl/cnt_dn.sv
// rtl/cnt_dn.sv - loadable down counter with match pulse and terminal count
//
// Purpose: counts from the loaded (or reset) value toward zero, strobes
// out_pulse the first cycle the count equals MATCH, and at zero either
// reloads the last loaded value (AUTO_RELOAD=1) or halts (AUTO_RELOAD=0).
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-low reset
//   bus  cnt_dn_if slave: en, load, load_val in; out, out_pulse, zero, busy out
// Priority at an edge: rst > load > en.

module cnt_dn #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] MATCH       = WIDTH'(55),
  parameter int               AUTO_RELOAD = 1
) (
  input  logic     clk,
  input  logic     rst,
  cnt_dn_if.slave  bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_r, reload_d;
  logic             match_d;
  logic             at_match;
  logic             at_zero;

  assign at_match = (out_q == MATCH);
  assign at_zero  = (out_q == '0);

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_r;
    if (bus.load) begin
      out_d    = bus.load_val;
      reload_d = bus.load_val;
      state_d  = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.en) begin
            if (!at_zero) begin
              out_d = out_q - ONE;
            end else if (AUTO_RELOAD != 0) begin
              // Terminal count: restart the lap from the last loaded value.
              out_d = reload_r;
            end else begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          // Parked at zero; only load or reset leave this state.
          state_d = HOLD;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q    <= '1;
      reload_r <= '1;
      state_q  <= RUN;
      match_d  <= 1'b0;
    end else begin
      out_q    <= out_d;
      reload_r <= reload_d;
      state_q  <= state_d;
      // Remembers whether MATCH was already showing, so a held or
      // re-loaded MATCH value does not strobe again.
      match_d  <= at_match;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_pulse = at_match & ~match_d;
  assign bus.zero      = at_zero;
  assign bus.busy      = (state_q == RUN);

endmodule

// File: tb/tb_cnt_dn.sv
// tb/tb_cnt_dn.sv - scoreboard bench for cnt_dn (reload and halt variants)

module tb_cnt_dn;

  typedef struct {
    int         id;
    bit         sel;
    logic [7:0] out;
    logic       pulse;
    logic       zero;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   step_id;
  exp_t sb[$];

  cnt_dn_if #(.WIDTH(8)) bus_a ();
  cnt_dn_if #(.WIDTH(8)) bus_h ();

  cnt_dn #(.WIDTH(8), .MATCH(8'd55), .AUTO_RELOAD(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  cnt_dn #(.WIDTH(8), .MATCH(8'd55), .AUTO_RELOAD(0)) dut_h (
    .clk (clk),
    .rst (rst),
    .bus (bus_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %0d, expected %0d", id, nm, act, exp);
    end
  endtask

  // Monitor: every half-cycle after an edge, compare the DUT against the
  // oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel == 1'b0) begin
        chk("a.out",   e.id, bus_a.out,              e.out);
        chk("a.pulse", e.id, {7'd0, bus_a.out_pulse}, {7'd0, e.pulse});
        chk("a.zero",  e.id, {7'd0, bus_a.zero},      {7'd0, e.zero});
        chk("a.busy",  e.id, {7'd0, bus_a.busy},      {7'd0, e.busy});
      end else begin
        chk("h.out",   e.id, bus_h.out,              e.out);
        chk("h.pulse", e.id, {7'd0, bus_h.out_pulse}, {7'd0, e.pulse});
        chk("h.zero",  e.id, {7'd0, bus_h.zero},      {7'd0, e.zero});
        chk("h.busy",  e.id, {7'd0, bus_h.busy},      {7'd0, e.busy});
      end
    end
  end

  // Drive one cycle of stimulus on the selected counter (the other idles),
  // then queue the state expected after that edge.
  task automatic step(input bit s, input logic r, input logic l, input logic e,
                      input logic [7:0] lv, input logic [7:0] eo,
                      input logic ep, input logic ez, input logic eb);
    exp_t x;
    rst = r;
    bus_a.load = (s == 1'b0) ? l : 1'b0;
    bus_a.en   = (s == 1'b0) ? e : 1'b0;
    bus_a.load_val = lv;
    bus_h.load = (s == 1'b1) ? l : 1'b0;
    bus_h.en   = (s == 1'b1) ? e : 1'b0;
    bus_h.load_val = lv;
    @(posedge clk);
    #1;
    step_id++;
    x.id = step_id; x.sel = s; x.out = eo; x.pulse = ep; x.zero = ez; x.busy = eb;
    sb.push_back(x);
  endtask

  localparam bit A = 1'b0;
  localparam bit H = 1'b1;

  initial begin
    int wait_cnt;
    errors = 0; checks = 0; step_id = 0;
    rst = 1'b0;
    bus_a.en = 0; bus_a.load = 0; bus_a.load_val = 0;
    bus_h.en = 0; bus_h.load = 0; bus_h.load_val = 0;

    // Reset state on both variants
    step(A, 0, 0, 0, 8'd0, 8'd255, 0, 0, 1);
    step(H, 0, 0, 0, 8'd0, 8'd255, 0, 0, 1);

    // Reset then count: 255 down to 55, pulse only on the 200th decrement
    for (int i = 1; i <= 200; i++)
      step(A, 1, 0, 1, 8'd0, 8'(255 - i), (i == 200), 0, 1);
    step(A, 1, 0, 1, 8'd0, 8'd54, 0, 0, 1);

    // Terminal count with reload: 3,2,1,0,3,2
    step(A, 1, 1, 0, 8'd3, 8'd3, 0, 0, 1);
    step(A, 1, 0, 1, 8'd0, 8'd2, 0, 0, 1);
    step(A, 1, 0, 1, 8'd0, 8'd1, 0, 0, 1);
    step(A, 1, 0, 1, 8'd0, 8'd0, 0, 1, 1);
    step(A, 1, 0, 1, 8'd0, 8'd3, 0, 0, 1);
    step(A, 1, 0, 1, 8'd0, 8'd2, 0, 0, 1);

    // Pulse during stall, re-arm behaviour
    step(A, 1, 1, 0, 8'd56, 8'd56, 0, 0, 1);
    step(A, 1, 0, 1, 8'd0,  8'd55, 1, 0, 1);
    for (int i = 0; i < 5; i++)
      step(A, 1, 0, 0, 8'd0, 8'd55, 0, 0, 1);
    step(A, 1, 1, 0, 8'd55, 8'd55, 0, 0, 1);
    step(A, 1, 1, 0, 8'd60, 8'd60, 0, 0, 1);
    step(A, 1, 1, 0, 8'd55, 8'd55, 1, 0, 1);

    // Priority: load over en, reset over load
    step(A, 1, 1, 1, 8'd100, 8'd100, 0, 0, 1);
    step(A, 0, 1, 1, 8'd7,   8'd255, 0, 0, 1);

    // Reset mid-count at 120, then counting resumes
    step(A, 1, 1, 0, 8'd120, 8'd120, 0, 0, 1);
    step(A, 0, 0, 1, 8'd0,   8'd255, 0, 0, 1);
    step(A, 1, 0, 1, 8'd0,   8'd254, 0, 0, 1);

    // Reset while pulse is showing: pulse drops, match history cleared
    step(A, 1, 1, 0, 8'd56, 8'd56, 0, 0, 1);
    step(A, 1, 0, 1, 8'd0,  8'd55, 1, 0, 1);
    step(A, 0, 0, 1, 8'd0,  8'd255, 0, 0, 1);
    step(A, 1, 1, 0, 8'd55, 8'd55, 1, 0, 1);

    // load_val = 0 with auto reload: stays at zero
    step(A, 1, 1, 0, 8'd0, 8'd0, 0, 1, 1);
    step(A, 1, 0, 1, 8'd0, 8'd0, 0, 1, 1);
    step(A, 1, 0, 1, 8'd0, 8'd0, 0, 1, 1);

    // Terminal count with halt: 2,1,0,0..., busy falls after 0 reached
    step(H, 1, 1, 0, 8'd2, 8'd2, 0, 0, 1);
    step(H, 1, 0, 1, 8'd0, 8'd1, 0, 0, 1);
    step(H, 1, 0, 1, 8'd0, 8'd0, 0, 1, 1);
    step(H, 1, 0, 1, 8'd0, 8'd0, 0, 1, 0);
    step(H, 1, 0, 1, 8'd0, 8'd0, 0, 1, 0);
    step(H, 1, 0, 0, 8'd0, 8'd0, 0, 1, 0);
    step(H, 1, 1, 1, 8'd10, 8'd10, 0, 0, 1);
    step(H, 1, 0, 1, 8'd0,  8'd9,  0, 0, 1);

    // Idle and let the monitor drain the scoreboard
    bus_a.en = 0; bus_a.load = 0;
    bus_h.en = 0; bus_h.load = 0;
    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnt_dn.md
# cnt_dn

Loadable down counter, the mirror of the team's 8-bit up counter with match pulse. It counts from a loaded (or reset) value toward zero and emits a single-cycle `out_pulse` the first cycle the count equals `MATCH`. It flags terminal count and, by parameter, auto-reloads or halts. It sits beside the up counter in timing and sequence blocks wherever a countdown with a mid-count strobe is needed.

## Interface
- `WIDTH`, default 8: counter width.
- `MATCH`, default 8'd55: count value that triggers `out_pulse`. With the default, the pulse fires 200 decrements after reset (255 − 200).
- `AUTO_RELOAD`, default 1: 1 = reload at terminal count, 0 = halt at zero.

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-low reset. Sampled on `clk` rising edge only.
- `en` input 1: count enable, one decrement per enabled cycle.
- `load` input 1: load strobe. Has priority over `en`.
- `load_val` input WIDTH: value captured on `load`.
- `out` output WIDTH: current count, registered.
- `out_pulse` output 1: one-cycle strobe on arrival at `MATCH`.
- `zero` output 1: high while `out == 0`.
- `busy` output 1: high in state RUN.

## Operation
- **Registers:** `out`, `reload_r` (last loaded value), `state` (RUN, HOLD) and `match_d` (previous-cycle value of `out == MATCH`).
- **Reset** (`rst == 0` at an edge):
  - `out` = all ones, `reload_r` = all ones, `state` = RUN, `match_d` = 0.
  - Reset overrides `load` and `en`.
- **Load** (`load == 1`, any state):
  - `out` <= `load_val`, `reload_r` <= `load_val`, `state` <= RUN.
  - `en` is ignored that cycle.
- **RUN, `en == 1`, `out != 0`:** `out` <= `out` − 1.
- **RUN, `en == 1`, `out == 0`:**
  - If `AUTO_RELOAD == 1`: `out` <= `reload_r` and stay in RUN.
  - Otherwise: `out` stays 0 and `state` <= HOLD.
  - There is never a wrap to all ones unless `reload_r` is all ones.
- **RUN, `en == 0`:** `out` holds.
- **HOLD:**
  - `out` holds at 0 and `en` is ignored.
  - The only exits are `load` or reset.
- **Outputs:**
  - `out_pulse` = (`out == MATCH`) AND NOT `match_d`. This is combinational from registers. `match_d` <= (`out == MATCH`) every non-reset edge.
  - `zero` = (`out == 0`). `busy` = (`state == RUN`).
- **Arithmetic:** unsigned, modulo 2^WIDTH. Decrement is never applied at 0.

## Timing
- **Reset values:** `out` = all ones, `out_pulse` = 0 (or 1 only if `MATCH` equals all ones, in the first post-reset cycle), `zero` = 0, `busy` = 1.
- **Latency:**
  - `load` to `out` = `load_val`: 1 cycle.
  - `en` to decrement visible: 1 cycle.
- **Pulse timing:**
  - `out_pulse` is high in exactly the first cycle `out` equals `MATCH`, whether reached by decrement, load or reload.
  - The pulse stays one cycle even if `en` stays low and `out` holds at `MATCH`.
- **Re-arming:**
  - Loading `MATCH` while `out` already equals `MATCH` produces no pulse, because `match_d` is already 1.
  - Leaving `MATCH` and returning (next reload lap) produces a new pulse.
- **Simultaneous events:** `rst` > `load` > `en`.
- **Reset mid-count:** takes effect on the next edge. `out_pulse` falls at that edge unless `MATCH` is all ones.
- **Reload lap length:** with `AUTO_RELOAD = 1` and `en` held high, `out` steps `reload_r` … 1, 0, `reload_r`, giving a period of `reload_r` + 1 cycles.
- **`load_val` = 0 with `AUTO_RELOAD = 1`:** `out` stays 0 and `zero` stays high.

## Test plan
- **Reset then count:** reset, then `en` = 1 for 200 cycles -> `out` steps 255 down to 55. `out_pulse` is high only in the cycle `out` = 55, which is the 200th enabled cycle after reset.
- **Terminal count with reload:** `AUTO_RELOAD = 1`, load 3, `en` high -> `out` = 3, 2, 1, 0, 3, 2. `zero` is high only at 0. `busy` stays 1.
- **Terminal count with halt:** `AUTO_RELOAD = 0`, load 2, `en` high -> `out` = 2, 1, 0, 0, … `busy` falls the cycle after 0 is reached. A later load 10 -> `out` = 10 and `busy` = 1.
- **Pulse during stall:** load 56, one `en` pulse (`out` = 55), then `en` low for 5 cycles -> `out_pulse` is high for exactly 1 cycle. Then load 55 -> no pulse. Then load 60, load 55 -> pulse.
- **Priority:** `load` and `en` high together with `load_val` = 100 -> `out` = 100, no decrement. `rst` = 0 together with `load` -> `out` = 255.
- **Reset mid-count:** reset asserted while at `out` = 120 -> `out` = 255 at the next edge and `match_d` is cleared. Counting resumes when `rst` returns to 1.
